t_ff_counter_bank: RTL and testbench
====================================

// Module: t_ff_counter_bank
// PURPOSE
//  Parametrised bank of WIDTH T-flip-flop stages with a per-cycle mode select.
//  Modes: hold, independent per-bit toggle, modulo-MODULUS up count, down count.
//  All four modes use the same T-stage datapath: next q = q ^ toggle vector.
//  Provides true and complemented outputs, parallel load and a terminal-count flag.
//  Used as the general toggle/counter primitive for the lab datapaths.
// PARAMETERS
//  WIDTH      4    number of T stages (bits of q)
//  MODULUS    16   count-mode period; legal range 2 <= MODULUS <= 2**WIDTH
//  RESET_VAL  0    q value after reset; must be < MODULUS
// PORTS
//  clk    in   1      rising-edge clock, sole clock
//  rst_n  in   1      synchronous reset, active-low
//  en     in   1      advance enable; 0 = hold (load still honoured)
//  mode   in   2      00 hold, 01 toggle, 10 count up, 11 count down
//  t      in   WIDTH  per-bit toggle request, used only in mode 01
//  load   in   1      parallel load of d
//  d      in   WIDTH  load value
//  q      out  WIDTH  stage outputs (registered)
//  q_n    out  WIDTH  complement of q (registered)
//  tc     out  1      terminal-count pulse (registered)
// BEHAVIOUR
//  - All state and outputs change only on posedge clk; no combinational in->out path.
//  - Priority per edge: rst_n=0 > load=1 > en=0 > mode.
//  - Reset (rst_n=0 at edge): q=RESET_VAL, q_n=~RESET_VAL, tc=0. Overrides load/en.
//  - load=1: q<=d regardless of en/mode; d is not clamped; tc<=0.
//  - en=0, load=0: q holds; tc<=0.
//  - mode 00: q holds; tc<=0.
//  - mode 01: toggle vector = t; q<=q^t; tc<=0. t=0 is a legal hold.
//  - mode 10 (up): toggle bit i = AND of q[i-1:0] (bit 0 always toggles).
//    If q >= MODULUS-1, then q<=0 and tc<=1 (wrap); otherwise tc<=0.
//  - mode 11 (down): toggle bit i = AND of ~q[i-1:0].
//    If q==0, then q<=MODULUS-1 and tc<=1 (wrap).
//    If q > MODULUS-1 (out of range after load/toggle), then q<=MODULUS-1 and tc<=0.
//    Otherwise q<=q-1 and tc<=0.
//  - Wrap handling may override the toggle vector; the result must equal the
//    stated value.
//  - tc is high for exactly the one cycle in which q shows the wrapped value.
//    Consecutive wraps (MODULUS=2 up) hold tc high on every wrap cycle.
//  - q_n == ~q in every cycle, including the first cycle after reset or load;
//    never lags q.
//  - Mode change between edges: takes effect at the next edge; q is not cleared.
//  - Up/down from a loaded out-of-range value follows the rules above.
//    No X propagation; no illegal states.
//  - Latency: one clock from inputs sampled to q/q_n/tc.
// TESTING
//  1 rst_n=0 for 2 edges with en=1, mode=10, load=1, d=5 -> q=RESET_VAL,
//    q_n=~RESET_VAL, tc=0.
//  2 WIDTH=4, MODULUS=10, up from 0 for 10 edges -> q=1..9,0;
//    tc=1 only when q=0; q_n=~q every cycle.
//  3 Down from q=0 -> q=9, tc=1; next edge q=8, tc=0.
//    Then en=0 for 3 edges -> q stays 8, tc=0.
//  4 Mode 01, t=4'b0101, from q=0 for 3 edges -> q=0101, 0000, 0101; tc=0 always.
//  5 Load d=12 (>=MODULUS):
//    - load plus en=0 -> q=12.
//    - Mode 10 -> q=0, tc=1.
//    - Reload 12, mode 11 -> q=9, tc=0.
//  6 Same edge with rst_n=0, load=1, d=7 -> q=RESET_VAL.
//    Next edge load=1, en=0, d=7 -> q=7, q_n=4'b1000.

Source files
------------

// File: rtl/t_ff_counter_bank.sv
// t_ff_counter_bank
//   A bank of WIDTH T-flip-flop stages. Every mode is a toggle vector that is
//   XORed into q on the edge: hold, per-bit toggle, modulo-MODULUS up count and
//   modulo-MODULUS down count. A parallel load, complemented outputs and a
//   terminal-count pulse are also provided.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low (q=RESET_VAL, q_n=~RESET_VAL, tc=0)
//   en     advance enable; 0 holds q (load still honoured)
//   mode   00 hold, 01 toggle by t, 10 count up, 11 count down
//   t      per-bit toggle request, used only in mode 01
//   load   parallel load of d (priority over en/mode)
//   d      load value, not clamped
//   q      registered stage outputs
//   q_n    registered complement of q
//   tc     registered terminal-count pulse, high on the cycle q shows a wrap
module t_ff_counter_bank #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_TGL  = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DN   = 2'b11;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  // Ripple-carry toggle pattern: bit i toggles when all lower bits of v are 1.
  // Called with q for up counting and ~q for down counting.
  function automatic logic [WIDTH-1:0] carry_vec(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] c;
    c[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = c[i-1] & v[i-1];
    end
    return c;
  endfunction

  // Up-count wrap: anything at or above the terminal value (including a
  // loaded out-of-range value) returns to 0; the toggle vector is overridden.
  function automatic logic [WIDTH-1:0] up_next(input logic [WIDTH-1:0] cur);
    if (cur >= MAX_Q) begin
      return '0;
    end
    return cur ^ carry_vec(cur);
  endfunction

  // Down-count wrap: 0 wraps to the terminal value, and an out-of-range value
  // is pulled back to the terminal value instead of counting down through
  // states outside the modulus.
  function automatic logic [WIDTH-1:0] dn_next(input logic [WIDTH-1:0] cur);
    if (cur == '0 || cur > MAX_Q) begin
      return MAX_Q;
    end
    return cur ^ carry_vec(~cur);
  endfunction

  logic [WIDTH-1:0] q_nxt_p0;
  logic             tc_nxt_p0;
  logic [WIDTH-1:0] q_p1;
  logic [WIDTH-1:0] q_n_p1;
  logic             tc_p1;

  // ---- stage p0: next-state selection from current q and inputs ----
  always_comb begin
    q_nxt_p0  = q_p1;
    tc_nxt_p0 = 1'b0;
    if (load) begin
      q_nxt_p0 = d;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_nxt_p0 = q_p1;
        MODE_TGL:  q_nxt_p0 = q_p1 ^ t;
        MODE_UP: begin
          q_nxt_p0  = up_next(q_p1);
          tc_nxt_p0 = (q_p1 >= MAX_Q);
        end
        MODE_DN: begin
          q_nxt_p0  = dn_next(q_p1);
          tc_nxt_p0 = (q_p1 == '0);
        end
        default: q_nxt_p0 = q_p1;
      endcase
    end
  end

  // ---- stage p1: output registers; q_n is registered from the same next
  // value so it never lags q ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_p1   <= RST_Q;
      q_n_p1 <= ~RST_Q;
      tc_p1  <= 1'b0;
    end else begin
      q_p1   <= q_nxt_p0;
      q_n_p1 <= ~q_nxt_p0;
      tc_p1  <= tc_nxt_p0;
    end
  end

  assign q   = q_p1;
  assign q_n = q_n_p1;
  assign tc  = tc_p1;

endmodule

// File: tb/tb_t_ff_counter_bank.sv
module tb_t_ff_counter_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         tc;

  t_ff_counter_bank #(.WIDTH(W), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .t    (t),
    .load (load),
    .d    (d),
    .q    (q),
    .q_n  (q_n),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // Drive one edge's inputs on the falling edge and queue what the DUT must
  // show after the following rising edge.
  task automatic step(input logic r, input logic ld, input logic e,
                      input logic [1:0] m, input logic [W-1:0] tv,
                      input logic [W-1:0] dv, input logic [W-1:0] eq,
                      input logic etc, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n = r; load = ld; en = e; mode = m; t = tv; d = dv;
    x.q = eq; x.tc = etc; x.name = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: the DUT presents a result every cycle; compare whenever an
  // expectation is pending.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (q !== x.q) begin
          errors++;
          $display("FAIL %s q: got %b expected %b", x.name, q, x.q);
        end
        checks++;
        if (q_n !== ~x.q) begin
          errors++;
          $display("FAIL %s q_n: got %b expected %b", x.name, q_n, ~x.q);
        end
        checks++;
        if (tc !== x.tc) begin
          errors++;
          $display("FAIL %s tc: got %b expected %b", x.name, tc, x.tc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; en = 1'b0; mode = 2'b00; t = '0; d = '0;

    // reset overrides load/en/mode
    step(0, 1, 1, 2'b10, 4'd0, 4'd5, 4'd0, 0, "reset1");
    step(0, 1, 1, 2'b10, 4'd0, 4'd5, 4'd0, 0, "reset2");

    // up count modulo 10
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 1, 2'b10, 4'd0, 4'd0, W'(i % 10), (i == 10), "up");
    end

    // down from 0 wraps to 9, then 8; en=0 holds
    step(1, 0, 1, 2'b11, 4'd0, 4'd0, 4'd9, 1, "down_wrap");
    step(1, 0, 1, 2'b11, 4'd0, 4'd0, 4'd8, 0, "down_8");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 2'b11, 4'd0, 4'd0, 4'd8, 0, "en0_hold");
    end

    // per-bit toggle from 0
    step(1, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, "load0");
    step(1, 0, 1, 2'b01, 4'b0101, 4'd0, 4'b0101, 0, "tgl1");
    step(1, 0, 1, 2'b01, 4'b0101, 4'd0, 4'b0000, 0, "tgl2");
    step(1, 0, 1, 2'b01, 4'b0101, 4'd0, 4'b0101, 0, "tgl3");
    step(1, 0, 1, 2'b01, 4'b0000, 4'd0, 4'b0101, 0, "tgl_t0");
    step(1, 0, 1, 2'b00, 4'b1111, 4'd0, 4'b0101, 0, "mode_hold");

    // out-of-range load, then up and down
    step(1, 1, 0, 2'b10, 4'd0, 4'd12, 4'd12, 0, "load12");
    step(1, 0, 1, 2'b10, 4'd0, 4'd0, 4'd0, 1, "up_oor");
    step(1, 1, 1, 2'b11, 4'd0, 4'd12, 4'd12, 0, "reload12");
    step(1, 0, 1, 2'b11, 4'd0, 4'd0, 4'd9, 0, "down_oor");

    // reset beats load, then load with en=0
    step(0, 1, 1, 2'b10, 4'd0, 4'd7, 4'd0, 0, "rst_vs_load");
    step(1, 1, 0, 2'b00, 4'd0, 4'd7, 4'd7, 0, "load7");
    step(1, 0, 1, 2'b11, 4'd0, 4'd0, 4'd6, 0, "down_6");
    step(1, 1, 0, 2'b10, 4'd0, 4'd8, 4'd8, 0, "load8");
    step(1, 0, 1, 2'b10, 4'd0, 4'd0, 4'd9, 0, "up_9");
    step(1, 0, 1, 2'b10, 4'd0, 4'd0, 4'd0, 1, "up_wrap2");
    step(1, 0, 1, 2'b10, 4'd0, 4'd0, 4'd1, 0, "up_after_wrap");

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
